// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI pin bundle plus byte-level tx/rx handshake for spi_slave
// Signals:
//   cs_n, sclk, mosi   SPI inputs from the master (asynchronous to clk)
//   miso, miso_oe      SPI data out and its drive enable
//   tx_data, tx_wr     byte to send and its write strobe
//   tx_full            tx buffer holds an unsent byte
//   rx_data, rx_valid  last received byte and its unread flag
//   rx_rd              acknowledge strobe clearing rx_valid (and overrun)
//   overrun            sticky receive overrun (only with SPI_SLAVE_OVERRUN_EN)
interface spi_slave_if;
    logic       cs_n;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic [7:0] tx_data;
    logic       tx_wr;
    logic       tx_full;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_rd;
    logic       overrun;

    modport slave (
        input  cs_n, sclk, mosi, tx_data, tx_wr, rx_rd,
        output miso, miso_oe, tx_full, rx_data, rx_valid, overrun
    );

    modport master (
        output cs_n, sclk, mosi, tx_data, tx_wr, rx_rd,
        input  miso, miso_oe, tx_full, rx_data, rx_valid, overrun
    );
endinterface

// File: rtl/spi_slave.sv
// spi_slave: mode-0 SPI slave, MSB first, one-byte tx buffer and rx holding register
// Ports:
//   clk    system clock, all state on its rising edge
//   rst_n  asynchronous active-low reset
//   bus    spi_slave_if.slave: SPI pins plus tx/rx byte handshake
// Build option: define SPI_SLAVE_OVERRUN_EN to build the sticky overrun flag;
// without it overrun is tied to 0.
module spi_slave (
    input  logic       clk,
    input  logic       rst_n,
    spi_slave_if.slave bus
);
    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t     state_q, state_d;
    logic [1:0] cs_q;
    logic [1:0] mosi_q;
    logic [2:0] sclk_q;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] tx_buf_q, tx_buf_d;
    logic       tx_full_q, tx_full_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       cs_s, mosi_s, rise, fall, active, load, done, wr_ok;

    assign cs_s   = cs_q[1];
    assign mosi_s = mosi_q[1];
    assign rise   = sclk_q[1] & ~sclk_q[2];
    assign fall   = ~sclk_q[1] & sclk_q[2];
    // active excludes the cycle in which synced cs_n has already risen, so a
    // coincident sclk edge cannot touch state while the transfer is aborting
    assign active = (state_q == ACTIVE) & ~cs_s;
    // a byte is fetched on entry to ACTIVE and on each falling edge at a byte boundary
    assign load   = ((state_q == IDLE) & ~cs_s) | (active & fall & (cnt_q == 3'd0));
    assign done   = active & rise & (cnt_q == 3'd7);
    // a write is only accepted into an empty buffer; a same-cycle load sees the old content
    assign wr_ok  = bus.tx_wr & ~tx_full_q;

    always_comb begin
        state_d    = cs_s ? IDLE : ACTIVE;
        cnt_d      = !active ? 3'd0 : rise ? cnt_q + 3'd1 : cnt_q;
        rx_shift_d = !active ? 8'h00 : rise ? {rx_shift_q[6:0], mosi_s} : rx_shift_q;
        tx_shift_d = load ? (tx_full_q ? tx_buf_q : 8'hFF)
                   : !active ? 8'hFF
                   : fall ? {tx_shift_q[6:0], 1'b1} : tx_shift_q;
        tx_full_d  = (tx_full_q & ~load) | wr_ok;
        tx_buf_d   = wr_ok ? bus.tx_data : tx_buf_q;
        rx_data_d  = done ? {rx_shift_q[6:0], mosi_s} : rx_data_q;
        rx_valid_d = done | (rx_valid_q & ~bus.rx_rd);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cs_q       <= 2'b11;
            mosi_q     <= 2'b11;
            sclk_q     <= 3'b000;
            cnt_q      <= 3'd0;
            tx_shift_q <= 8'hFF;
            tx_buf_q   <= 8'h00;
            tx_full_q  <= 1'b0;
            rx_shift_q <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cs_q       <= {cs_q[0], bus.cs_n};
            mosi_q     <= {mosi_q[0], bus.mosi};
            sclk_q     <= {sclk_q[1:0], bus.sclk};
            cnt_q      <= cnt_d;
            tx_shift_q <= tx_shift_d;
            tx_buf_q   <= tx_buf_d;
            tx_full_q  <= tx_full_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    logic overrun_q, overrun_d;

    // rx_rd wins over a concurrent completion since that byte is being accepted
    assign overrun_d = ~bus.rx_rd & (overrun_q | (done & rx_valid_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) overrun_q <= 1'b0;
        else        overrun_q <= overrun_d;
    end

    assign bus.overrun = overrun_q;
`else
    assign bus.overrun = 1'b0;
`endif

    assign bus.miso     = tx_shift_q[7];
    assign bus.miso_oe  = ~cs_s;
    assign bus.tx_full  = tx_full_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed mode-0 transfers with an rx scoreboard and immediate-assertion checks
module tb_spi_slave;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    logic [7:0] rx_q[$];
    logic [7:0] mi;

    spi_slave_if bus();

    spi_slave dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] d);
        bus.tx_data = d;
        bus.tx_wr = 1'b1;
        tick(1);
        bus.tx_wr = 1'b0;
    endtask

    task automatic rd();
        bus.rx_rd = 1'b1;
        tick(1);
        bus.rx_rd = 1'b0;
    endtask

    task automatic cs_low();
        bus.cs_n = 1'b0;
        tick(8);
    endtask

    task automatic cs_high();
        tick(8);
        bus.cs_n = 1'b1;
        tick(8);
    endtask

    // sclk phases of 8 clk each; miso sampled at the end of each low phase
    task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] m);
        m = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            bus.mosi = mo[7-i];
            tick(8);
            m = {m[6:0], bus.miso};
            bus.sclk = 1'b1;
            tick(8);
            bus.sclk = 1'b0;
        end
        if (nbits == 8) rx_q.push_back(mo);
    endtask

    task automatic check_rx(input string tag);
        logic [7:0] e;
        e = 8'hxx;
        if (rx_q.size() > 0) e = rx_q.pop_front();
        chk({tag, "_valid"}, {7'd0, bus.rx_valid}, 8'd1);
        chk(tag, bus.rx_data, e);
    endtask

    initial begin
        bus.cs_n = 1'b1;
        bus.sclk = 1'b0;
        bus.mosi = 1'b1;
        bus.tx_data = 8'h00;
        bus.tx_wr = 1'b0;
        bus.rx_rd = 1'b0;
        tick(3);
        chk("rst_miso", {7'd0, bus.miso}, 8'd1);
        chk("rst_oe", {7'd0, bus.miso_oe}, 8'd0);
        chk("rst_full", {7'd0, bus.tx_full}, 8'd0);
        chk("rst_rxd", bus.rx_data, 8'h00);
        chk("rst_rxv", {7'd0, bus.rx_valid}, 8'd0);
        chk("rst_ovr", {7'd0, bus.overrun}, 8'd0);
        rst_n = 1'b1;
        tick(3);

        wr(8'hA5);
        chk("t1_full_set", {7'd0, bus.tx_full}, 8'd1);
        cs_low();
        chk("t1_oe", {7'd0, bus.miso_oe}, 8'd1);
        chk("t1_full_clr", {7'd0, bus.tx_full}, 8'd0);
        xfer(8'h3C, 8, mi);
        chk("t1_miso", mi, 8'hA5);
        check_rx("t1_rx");
        cs_high();
        chk("t1_oe_off", {7'd0, bus.miso_oe}, 8'd0);
        rd();
        chk("t1_rd", {7'd0, bus.rx_valid}, 8'd0);

        cs_low();
        xfer(8'h01, 8, mi);
        chk("t2_miso0", mi, 8'hFF);
        check_rx("t2_rx0");
        rd();
        chk("t2_rd0", {7'd0, bus.rx_valid}, 8'd0);
        xfer(8'h80, 8, mi);
        chk("t2_miso1", mi, 8'hFF);
        check_rx("t2_rx1");
        rd();
        cs_high();

        wr(8'h11);
        wr(8'h22);
        chk("t3_full", {7'd0, bus.tx_full}, 8'd1);
        cs_low();
        xfer(8'h00, 8, mi);
        chk("t3_miso", mi, 8'h11);
        check_rx("t3_rx");
        cs_high();
        rd();
        chk("t3_full_clr", {7'd0, bus.tx_full}, 8'd0);

        cs_low();
        xfer(8'hFF, 5, mi);
        cs_high();
        chk("t4_abort_rxv", {7'd0, bus.rx_valid}, 8'd0);
        chk("t4_abort_rxd", bus.rx_data, 8'h00);
        cs_low();
        xfer(8'hC3, 8, mi);
        check_rx("t4_rx");
        cs_high();
        rd();

        cs_low();
        xfer(8'h5A, 8, mi);
        xfer(8'h96, 8, mi);
        void'(rx_q.pop_front());
        check_rx("t5_rx");
`ifdef SPI_SLAVE_OVERRUN_EN
        chk("t5_ovr", {7'd0, bus.overrun}, 8'd1);
`else
        chk("t5_ovr", {7'd0, bus.overrun}, 8'd0);
`endif
        cs_high();
        rd();
        chk("t5_ovr_clr", {7'd0, bus.overrun}, 8'd0);
        chk("t5_rxv_clr", {7'd0, bus.rx_valid}, 8'd0);

        cs_low();
        xfer(8'hE7, 8, mi);
        check_rx("t6_rx");
        wr(8'h77);
        xfer(8'h00, 3, mi);
        rst_n = 1'b0;
        #1;
        chk("t6_miso", {7'd0, bus.miso}, 8'd1);
        chk("t6_oe", {7'd0, bus.miso_oe}, 8'd0);
        chk("t6_full", {7'd0, bus.tx_full}, 8'd0);
        chk("t6_rxv", {7'd0, bus.rx_valid}, 8'd0);
        chk("t6_rxd", bus.rx_data, 8'h00);
        chk("t6_ovr", {7'd0, bus.overrun}, 8'd0);
        bus.cs_n = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(4);

        wr(8'h3C);
        cs_low();
        xfer(8'h69, 8, mi);
        chk("t7_miso", mi, 8'h3C);
        check_rx("t7_rx");
        cs_high();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have no parameters; all sizes are fixed by this document.
REQ-002 clk  input  1  system clock; all state SHALL be clocked on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 cs_n  input  1  SPI chip select, active low, asynchronous to clk.
REQ-005 sclk  input  1  SPI serial clock, mode 0 (idle low), asynchronous to clk.
REQ-006 mosi  input  1  SPI data in, MSB first.
REQ-007 miso  output  1  SPI data out, MSB first.
REQ-008 miso_oe  output  1  MISO drive enable, 1 while the synchronized cs_n is low.
REQ-009 tx_data  input  8  byte to transmit.
REQ-010 tx_wr  input  1  write strobe for tx_data.
REQ-011 tx_full  output  1  tx buffer holds an unsent byte.
REQ-012 rx_data  output  8  last received byte.
REQ-013 rx_valid  output  1  rx_data holds an unread byte.
REQ-014 rx_rd  input  1  acknowledge strobe; clears rx_valid.
REQ-015 overrun  output  1  sticky receive-overrun flag (see Configuration).

Function
REQ-016 cs_n, sclk and mosi SHALL each pass through a 2-flop synchronizer; a third sclk flop SHALL provide edge detection (rise = s2&~s3, fall = ~s2&s3).
REQ-017 Supported sclk: high and low phases each >= 4 clk periods; faster sclk is out of scope.
REQ-018 State machine: IDLE (synced cs_n high) and ACTIVE (synced cs_n low); IDLE->ACTIVE on synced cs_n falling, ACTIVE->IDLE on synced cs_n rising.
REQ-019 On IDLE->ACTIVE: bit counter = 0; tx shift register loads the tx buffer if tx_full=1, else 8'hFF; tx_full clears if loaded.
REQ-020 miso SHALL equal tx shift register bit 7 at all times; the shift register holds 8'hFF in IDLE.
REQ-021 On sclk rise in ACTIVE: rx shift <= {rx shift[6:0], synced mosi}; bit counter increments modulo 8.
REQ-022 On the sclk rise that completes bit 7: in the same clk cycle rx_data <= {rx shift[6:0], synced mosi} and rx_valid <= 1 (3 clk edges after the pin edge, +1 for sampling phase).
REQ-023 On sclk fall in ACTIVE: if the bit counter is 0 (byte boundary), load the next byte per REQ-019; otherwise shift the tx shift register left, filling 1.
REQ-024 tx_wr with tx_full=0: tx buffer <= tx_data, tx_full <= 1; tx_wr with tx_full=1 SHALL be ignored.
REQ-025 tx_wr in the same cycle as a buffer load: the load uses the prior buffer content (or 8'hFF if empty); the written byte stays buffered.
REQ-026 rx_rd SHALL clear rx_valid; rx_rd concurrent with byte completion leaves rx_valid=1 with the new byte.
REQ-027 cs_n rising mid-byte: partial rx bits discarded, bit counter reset to 0, rx_data/rx_valid/tx buffer unchanged.
REQ-028 sclk edges while in IDLE SHALL have no effect.

Reset
REQ-029 rst_n low SHALL immediately force: IDLE, bit counter 0, synchronizers to idle values (cs_n 1, sclk 0, mosi 1), tx shift 8'hFF (miso=1), miso_oe 0, tx_full 0, tx buffer 8'h00, rx_data 8'h00, rx_valid 0, overrun 0.
REQ-030 Reset asserted mid-transfer SHALL abort it; after release the block waits for a fresh cs_n falling edge.

Configuration
REQ-031 Macro SPI_SLAVE_OVERRUN_EN defined: overrun sets when a byte completes while rx_valid=1 and rx_rd=0; rx_data is still overwritten; overrun clears only on rx_rd or reset.
REQ-032 SPI_SLAVE_OVERRUN_EN undefined: overrun is constant 0 and no overrun logic is built; overwrite behaviour is unchanged.

Verification
REQ-033 tx_wr 8'hA5, then cs_n low, 8 mode-0 clocks with mosi=8'h3C -> miso shows 1,0,1,0,0,1,0,1; rx_data=8'h3C, rx_valid=1; tx_full=0.
REQ-034 No tx_wr, two-byte transfer mosi 8'h01,8'h80 -> miso all 1s; rx_valid after each byte; rx_rd between bytes returns 8'h01 then 8'h80.
REQ-035 tx_wr 8'h11 then tx_wr 8'h22 before cs_n low -> second write ignored; miso sends 8'h11.
REQ-036 cs_n high after 5 sclk cycles, then full byte 8'hC3 -> rx_data=8'hC3 only; no rx_valid from the aborted byte.
REQ-037 Two bytes without rx_rd, macro defined -> overrun=1, rx_data=second byte; macro undefined -> overrun stays 0.
REQ-038 rst_n pulsed low mid-byte -> all outputs at REQ-029 values within the same cycle; next full transfer correct.
